counter_bank_arb: RTL and testbench



---
 rtl/counter_bank_arb.sv | 107 ++++++++++
 tb/tb_counter_bank_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/counter_bank_arb.sv
// Four WIDTH-bit event counters that share a single incrementer; a round-robin
// arbiter picks which requesting channel advances each cycle.
module counter_bank_arb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    input  logic [3:0]       clr,
    output logic [3:0]       wrap,
    input  logic             wrap_clr,
    input  logic             rd_en,
    input  logic [1:0]       rd_sel,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] count_val [4];
    logic [3:0]       gnt_reg;
    logic [3:0]       gnt_next;
    logic [3:0]       wrap_reg;
    logic [3:0]       wrap_next;
    logic [1:0]       ptr_reg;
    logic [1:0]       ptr_next;
    logic             rd_valid_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic [WIDTH-1:0] rd_data_next;

    logic [3:0]       eligible;
    logic [3:0]       hit;
    logic             win_valid;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;
    logic [WIDTH-1:0] inc_operand;
    logic [WIDTH-1:0] inc_result;
    logic             inc_carry;

    // Last cycle's grantee sits out one cycle, so a requester that drops req
    // on seeing gnt gets exactly one increment; a clear also blocks the grant.
    assign eligible = req & ~gnt_reg & ~clr;

    // Scan from the farthest offset back to ptr so the nearest eligible wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_reg;
        scan_idx  = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_reg + 2'(k);
            if (eligible[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign inc_operand              = count_val[win_idx];
    assign {inc_carry, inc_result}  = {1'b0, inc_operand} + {{WIDTH{1'b0}}, 1'b1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH-1:0] cnt_next;

            assign hit[gi]       = win_valid && (win_idx == 2'(gi));
            assign cnt_next      = clr[gi] ? '0 : (hit[gi] ? inc_result : cnt_reg);
            // A wrap on this edge overrides a simultaneous wrap_clr.
            assign wrap_next[gi] = (hit[gi] & inc_carry) | (wrap_reg[gi] & ~wrap_clr);
            assign count_val[gi] = cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign gnt_next     = hit;
    assign ptr_next     = win_valid ? (win_idx + 2'd1) : ptr_reg;
    // Readback samples the count as held before this edge's increment/clear.
    assign rd_data_next = rd_en ? count_val[rd_sel] : rd_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_reg      <= '0;
            wrap_reg     <= '0;
            ptr_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            gnt_reg      <= gnt_next;
            wrap_reg     <= wrap_next;
            ptr_reg      <= ptr_next;
            rd_valid_reg <= rd_en;
            rd_data_reg  <= rd_data_next;
        end
    end

    assign gnt      = gnt_reg;
    assign wrap     = wrap_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_counter_bank_arb.sv
// Bench for counter_bank_arb: vector tables plus hand sequences; read results
// are queued when the read is issued and checked when rd_valid returns.
module tb_counter_bank_arb;

    localparam int W = 8;

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   clr;
        logic         wclr;
        logic         rd_en;
        logic [1:0]   rd_sel;
        logic [W-1:0] exp_rd;
        logic [3:0]   exp_gnt;
        logic [3:0]   exp_wrap;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [3:0]   clr;
    logic [3:0]   wrap;
    logic         wrap_clr;
    logic         rd_en;
    logic [1:0]   rd_sel;
    logic         rd_valid;
    logic [W-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl_single[$];
    vec_t tbl_fair[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_rd;

    counter_bank_arb #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .clr      (clr),
        .wrap     (wrap),
        .wrap_clr (wrap_clr),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mkv(input logic [3:0] r, input logic [3:0] c, input logic wc,
                                 input logic re, input logic [1:0] rs, input logic [W-1:0] erd,
                                 input logic [3:0] eg, input logic [3:0] ew);
        vec_t v;
        v.req = r; v.clr = c; v.wclr = wc; v.rd_en = re; v.rd_sel = rs;
        v.exp_rd = erd; v.exp_gnt = eg; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        req = v.req; clr = v.clr; wrap_clr = v.wclr; rd_en = v.rd_en; rd_sel = v.rd_sel;
        if (v.rd_en) exp_q.push_back(v.exp_rd);
        @(posedge clk);
        #1;
        chk({tag, "/gnt"}, 32'(gnt), 32'(v.exp_gnt));
        chk({tag, "/wrap"}, 32'(wrap), 32'(v.exp_wrap));
        chk({tag, "/rd_valid"}, 32'(rd_valid), 32'(v.rd_en));
        if (v.rd_en && exp_q.size() > 0) last_rd = exp_q.pop_front();
        chk({tag, "/rd_data"}, 32'(rd_data), 32'(last_rd));
    endtask

    initial begin
        // Single channel: ten cycles of req[2], then read it back.
        for (int i = 0; i < 10; i++)
            tbl_single.push_back(mkv(4'b0100, 4'b0, 1'b0, 1'b0, 2'd0, '0,
                                     (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0));
        tbl_single.push_back(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd2, 8'h05, 4'b0000, 4'b0));
        tbl_single.push_back(mkv(4'b0000, 4'b0, 1'b0, 1'b0, 2'd0, '0, 4'b0000, 4'b0));
        // Fairness from ptr=0 and zero counts: rotation 0,1,2,3 twice.
        for (int i = 0; i < 8; i++)
            tbl_fair.push_back(mkv(4'b1111, 4'b0, 1'b0, 1'b0, 2'd0, '0, 4'(1 << (i % 4)), 4'b0));
        for (int i = 0; i < 4; i++)
            tbl_fair.push_back(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'(i), 8'h02, 4'b0000, 4'b0));

        reset = 1'b0; req = '0; clr = '0; wrap_clr = 1'b0; rd_en = 1'b0; rd_sel = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/gnt", 32'(gnt), 32'h0);
        chk("reset/wrap", 32'(wrap), 32'h0);
        chk("reset/rd_valid", 32'(rd_valid), 32'h0);
        chk("reset/rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl_single[i]) apply(tbl_single[i], $sformatf("single%0d", i));

        // Reset mid-operation with a grant and a read result outstanding.
        apply(mkv(4'b0100, 4'b0, 1'b0, 1'b1, 2'd2, 8'h05, 4'b0100, 4'b0), "pre_rst");
        #2;
        reset = 1'b0;
        #1;
        last_rd = '0;
        chk("async_rst/gnt", 32'(gnt), 32'h0);
        chk("async_rst/wrap", 32'(wrap), 32'h0);
        chk("async_rst/rd_valid", 32'(rd_valid), 32'h0);
        chk("async_rst/rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        req = 4'b1111; rd_en = 1'b1; rd_sel = 2'd2;
        @(posedge clk);
        #1;
        chk("held_rst/gnt", 32'(gnt), 32'h0);
        chk("held_rst/rd_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1; req = '0; rd_en = 1'b0;
        for (int i = 0; i < 4; i++)
            apply(mkv(4'b0, 4'b0, 1'b0, 1'b1, 2'(i), 8'h00, 4'b0, 4'b0), $sformatf("rst_rd%0d", i));

        foreach (tbl_fair[i]) apply(tbl_fair[i], $sformatf("fair%0d", i));

        // Clear beats increment: bring count[1] from 2 to 0x30 first.
        for (int i = 0; i < 92; i++)
            apply(mkv(4'b0010, 4'b0, 1'b0, 1'b0, 2'd0, '0, (i % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0), "inc1");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd1, 8'h30, 4'b0000, 4'b0), "rd1_pre");
        apply(mkv(4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0, '0, 4'b0000, 4'b0), "clr1");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd1, 8'h00, 4'b0000, 4'b0), "rd1_post");

        // Read coherence: count[0] from 2 to 7, then read in the granting cycle.
        for (int i = 0; i < 10; i++)
            apply(mkv(4'b0001, 4'b0, 1'b0, 1'b0, 2'd0, '0, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0), "inc0");
        apply(mkv(4'b0001, 4'b0, 1'b0, 1'b1, 2'd0, 8'h07, 4'b0001, 4'b0), "coh_rd");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd0, 8'h08, 4'b0000, 4'b0), "coh_rd2");

        // Wrap: count[3] from 2 to all-ones, wrap, then wrap again under wrap_clr.
        for (int i = 0; i < 506; i++)
            apply(mkv(4'b1000, 4'b0, 1'b0, 1'b0, 2'd0, '0, (i % 2 == 0) ? 4'b1000 : 4'b0000, 4'b0), "inc3a");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd3, 8'hFF, 4'b0000, 4'b0), "rd3_ff");
        apply(mkv(4'b1000, 4'b0, 1'b0, 1'b0, 2'd0, '0, 4'b1000, 4'b1000), "wrap3");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd3, 8'h00, 4'b0000, 4'b1000), "rd3_0");
        for (int i = 0; i < 510; i++)
            apply(mkv(4'b1000, 4'b0, 1'b0, 1'b0, 2'd0, '0, (i % 2 == 0) ? 4'b1000 : 4'b0000, 4'b1000), "inc3b");
        apply(mkv(4'b1000, 4'b0, 1'b1, 1'b0, 2'd0, '0, 4'b1000, 4'b1000), "wrap_vs_clr");
        apply(mkv(4'b0000, 4'b0, 1'b1, 1'b0, 2'd0, '0, 4'b0000, 4'b0000), "wrap_clr");
        apply(mkv(4'b0000, 4'b0, 1'b0, 1'b1, 2'd3, 8'h00, 4'b0000, 4'b0000), "rd3_end");

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
